// File: rtl/multdiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   - FSM state encoding (IDLE/RUN/FIX/DONE)
//   - opcode enum (OP_MULT, OP_DIV)
//   - width and iteration-count constants
package multdiv_pkg;

  localparam int WIDTH     = 32;
  localparam int ITER      = 32;
  // Cycle offset (after the start edge) at which the sign-fix step runs
  localparam int FIX_CYCLE = ITER + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

endpackage

// File: rtl/multdiv_seq_addsub.sv
// Shared add/subtract datapath for multdiv_seq.
//   a, b     : WIDTH-bit operands
//   sub_bit  : 1 -> a - b (b inverted, carry-in 1); 0 -> a + b
//   sum      : WIDTH-bit result
//   cout     : carry out of the MSB (for subtract: 1 means a >= b unsigned)
module addsub_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub_bit,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   full;

  assign b_x  = b ^ {WIDTH{sub_bit}};
  assign full = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub_bit};
  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];

endmodule

// File: rtl/multdiv_seq.sv
// Multi-cycle signed 32-bit multiply (radix-2 Booth) and divide (restoring,
// on magnitudes) sharing one add/subtract unit.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   ctrl_MULT / ctrl_DIV    : one-cycle start pulses (multiply wins if both)
//   data_operandA/B         : operands, sampled only at the start edge
//   data_result             : product low word or quotient (registered)
//   data_exception          : multiply overflow or divide-by-zero
//   data_resultRDY          : one-cycle completion pulse
// Optional: define MULTDIV_EARLY_OUT_EN to finish zero-operand multiplies and
// divide-by-zero two cycles after the start instead of the full 34.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v) + WIDTH'(1'b1) : v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  // Multiply: {hi, lo, qm1} is the Booth product register, m the multiplicand.
  // Divide:   hi is the partial remainder, lo the quotient, m is |divisor|.
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic             qm1_q, qm1_d, neg_q, neg_d, dz_q, dz_d, early_q, early_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_sub, add_cout;
  logic             start, early_start, shift_in, ovf;
  logic [WIDTH:0]   top_bits;

  addsub_unit #(.WIDTH(WIDTH)) u_addsub (
    .a       (add_a),
    .b       (add_b),
    .sub_bit (add_sub),
    .sum     (add_sum),
    .cout    (add_cout)
  );

  assign start = ctrl_MULT | ctrl_DIV;

`ifdef MULTDIV_EARLY_OUT_EN
  always_comb begin
    early_start = 1'b0;
    if (ctrl_MULT) early_start = (data_operandA == '0) || (data_operandB == '0);
    else if (ctrl_DIV) early_start = (data_operandB == '0);
  end
`else
  assign early_start = 1'b0;
`endif

  // The Booth partial sum can need 33 bits; its true sign is recovered from
  // the carry-out so the arithmetic shift never loses it.
  assign shift_in = add_a[WIDTH-1] ^ (add_b[WIDTH-1] ^ add_sub) ^ add_cout;

  // Product fits signed WIDTH bits iff bits [2W-1:W-1] are all equal.
  assign top_bits = {hi_q, lo_q[WIDTH-1]};
  assign ovf      = !((&top_bits) || (~|top_bits));

  // Operand routing for the shared adder
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    if (state_q == ST_RUN) begin
      if (op_q == OP_MULT) begin
        add_a = hi_q;
        case ({lo_q[0], qm1_q})
          2'b01:   add_b = m_q;
          2'b10: begin
            add_b   = m_q;
            add_sub = 1'b1;
          end
          default: ;
        endcase
      end else begin
        add_a   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        add_b   = m_q;
        add_sub = 1'b1;
      end
    end else if (state_q == ST_FIX && op_q == OP_DIV) begin
      // 0 - Q: negate the quotient
      add_b   = lo_q;
      add_sub = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    qm1_d    = qm1_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    early_d  = early_q;
    result_d = result_q;
    exc_d    = exc_q;
    if (start) begin
      cnt_d   = '0;
      early_d = early_start;
      state_d = early_start ? ST_FIX : ST_RUN;
      hi_d    = '0;
      qm1_d   = 1'b0;
      if (ctrl_MULT) begin
        op_d  = OP_MULT;
        lo_d  = data_operandB;
        m_d   = data_operandA;
        neg_d = 1'b0;
        dz_d  = 1'b0;
      end else begin
        op_d  = OP_DIV;
        lo_d  = mag(data_operandA);
        m_d   = mag(data_operandB);
        neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dz_d  = (data_operandB == '0);
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIX;
          if (op_q == OP_MULT) begin
            hi_d  = {shift_in, add_sum[WIDTH-1:1]};
            lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
            qm1_d = lo_q[0];
          end else begin
            // Carry-out set means the trial subtraction did not go negative
            hi_d = add_cout ? add_sum : add_a;
            lo_d = {lo_q[WIDTH-2:0], add_cout};
          end
        end
        ST_FIX: begin
          state_d = ST_DONE;
          if (early_q) begin
            result_d = '0;
            exc_d    = (op_q == OP_DIV);
          end else if (op_q == OP_MULT) begin
            result_d = lo_q;
            exc_d    = ovf;
          end else if (dz_q) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            result_d = neg_q ? add_sum : lo_q;
            exc_d    = 1'b0;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  always_ff @(posedge clock) begin
    op_q    <= op_d;
    hi_q    <= hi_d;
    lo_q    <= lo_d;
    m_q     <= m_d;
    qm1_q   <= qm1_d;
    neg_q   <= neg_d;
    dz_q    <= dz_d;
    early_q <= early_d;
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == ST_DONE);

endmodule
